paper_sequencer: RTL

PAPER_SEQUENCER -- requirements
Module: paper_sequencer

---
 rtl/paper_pkg.sv | 23 ++
 rtl/paper_decode.sv | 30 +++
 rtl/paper_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/paper_pkg.sv
// paper_pkg: constants shared by the paper sequencer and its decoder.
//   DEF_PC_W  default program-counter / operand width (16-word program)
//   OP_*      2-bit opcodes carried in the top of each instruction word
//   state_t   sequencer FSM state encoding
package paper_pkg;

  localparam int DEF_PC_W = 4;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JNO  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT_ACK,
    ST_HALT
  } state_t;

endpackage

// File: rtl/paper_decode.sv
// paper_decode: maps a 2-bit opcode to one-hot command strobes.
//   opcode   in   instruction opcode
//   is_inc   out  opcode is INC
//   is_jno   out  opcode is JNO (jump if no overflow)
//   is_clr   out  opcode is CLR
//   is_halt  out  opcode is HALT
module paper_decode
  import paper_pkg::*;
(
  input  logic [1:0] opcode,
  output logic       is_inc,
  output logic       is_jno,
  output logic       is_clr,
  output logic       is_halt
);

  always_comb begin
    is_inc  = 1'b0;
    is_jno  = 1'b0;
    is_clr  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_INC:  is_inc  = 1'b1;
      OP_JNO:  is_jno  = 1'b1;
      OP_CLR:  is_clr  = 1'b1;
      default: is_halt = 1'b1;
    endcase
  end

endmodule

// File: rtl/paper_sequencer.sv
// paper_sequencer: tiny program sequencer driving a counter datapath.
// Each instruction walks FETCH -> DECODE -> EXEC (-> WAIT_ACK for INC/CLR).
//   clk         in   clock, all state on rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   level; starts at PC 0 from IDLE or HALT
//   mem_addr    out  program-memory address (= pc)
//   mem_rd      out  one-cycle read strobe, data returns the next cycle
//   mem_data    in   instruction word {opcode, operand}
//   inc_pulse   out  one-cycle increment command
//   clr_pulse   out  one-cycle clear command
//   dp_ack      in   datapath completion strobe
//   sta         in   datapath overflow status, valid with dp_ack
//   jump_pulse  out  one cycle when a JNO branch is taken
//   busy        out  not IDLE and not HALT
//   halted      out  in HALT
//   pc          out  program counter
module paper_sequencer
  import paper_pkg::*;
#(
  parameter int PC_W = DEF_PC_W,
  parameter int OP_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [PC_W-1:0]      mem_addr,
  output logic                 mem_rd,
  input  logic [OP_W+PC_W-1:0] mem_data,
  output logic                 inc_pulse,
  output logic                 clr_pulse,
  input  logic                 dp_ack,
  input  logic                 sta,
  output logic                 jump_pulse,
  output logic                 busy,
  output logic                 halted,
  output logic [PC_W-1:0]      pc
);

  localparam logic [PC_W-1:0] PC_ONE = 1;

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [OP_W+PC_W-1:0]   ir_q, ir_d;
  logic                   sta_q, sta_d;

  logic [OP_W-1:0]        opcode;
  logic [PC_W-1:0]        operand;
  logic                   is_inc, is_jno, is_clr, is_halt;

  assign opcode  = ir_q[OP_W+PC_W-1 -: OP_W];
  assign operand = ir_q[PC_W-1:0];

  paper_decode u_decode (
    .opcode  (opcode),
    .is_inc  (is_inc),
    .is_jno  (is_jno),
    .is_clr  (is_clr),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      sta_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sta_q   <= sta_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    sta_d      = sta_q;
    mem_rd     = 1'b0;
    inc_pulse  = 1'b0;
    clr_pulse  = 1'b0;
    jump_pulse = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          sta_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_rd  = 1'b1;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        // Memory answers one cycle after the read strobe, i.e. now.
        ir_d    = mem_data;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_inc) begin
          inc_pulse = 1'b1;
          state_d   = ST_WAIT_ACK;
        end else if (is_clr) begin
          clr_pulse = 1'b1;
          state_d   = ST_WAIT_ACK;
        end else if (is_jno) begin
          // Branch on the status captured at the last ack, not live sta.
          if (!sta_q) begin
            pc_d       = operand;
            jump_pulse = 1'b1;
          end else begin
            pc_d  = pc_q + PC_ONE;
            sta_d = 1'b0;
          end
          state_d = ST_FETCH;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_WAIT_ACK: begin
        if (dp_ack) begin
          sta_d   = sta;
          pc_d    = pc_q + PC_ONE;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = pc_q;
  assign pc       = pc_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted   = (state_q == ST_HALT);

endmodule
